// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode constants, fetch state and output types, stop-detect helper
package cpu_pkg;
   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] FUNC_STOP = 6'b111110;
   localparam logic [31:0] INST_NOP = 32'h0;
   localparam int PC_W = 10;
   typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t;
   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [31:0] inst;
      logic valid;
   } fetch_out_t;
   function automatic logic is_stop(input logic [31:0] i);
      return (i & 32'hFC00_003F) == {OP_SPECIAL, 20'h0, FUNC_STOP};
   endfunction
endpackage

// File: rtl/fetch.sv
// fetch: owns the PC, reads the 1-cycle instruction BRAM and hands {pc, inst, valid} to decode
module fetch
   import cpu_pkg::*;
#(
   parameter int INST_SIZE = 10,
   parameter logic [INST_SIZE-1:0] RESET_PC = '0
) (
   input logic clk,
   input logic rst,
   input logic start,
   input logic stall,
   input logic redirect,
   input logic [INST_SIZE-1:0] redirect_pc,
   output logic [INST_SIZE-3:0] imem_addr,
   output logic imem_en,
   input logic [31:0] imem_rdata,
   output logic [INST_SIZE-1:0] pc,
   output logic [31:0] inst,
   output logic valid,
   output logic halted,
   output logic [31:0] fetch_count
);
   fetch_state_t state;
   logic [INST_SIZE-1:0] pc_reg, pc_d1;
   logic inflight, stop, take;
   assign imem_en = state == RUN && (!stall || redirect);
   assign imem_addr = pc_reg[INST_SIZE-1:2];
   assign stop = inflight && is_stop(imem_rdata);
   // a redirect landing on the stop word squashes it, so no halt and no delivery
   assign take = inflight && !(stop && redirect);
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         pc_reg <= RESET_PC;
         pc_d1 <= '0;
         inflight <= 1'b0;
         pc <= '0;
         inst <= INST_NOP;
         valid <= 1'b0;
         halted <= 1'b0;
         fetch_count <= '0;
      end else if (state != RUN) begin
         pc <= '0;
         inst <= INST_NOP;
         valid <= 1'b0;
         if (state == IDLE && start) begin
            state <= RUN;
            pc_reg <= RESET_PC;
         end
      end else if (imem_en) begin
         pc_d1 <= pc_reg;
         inflight <= !redirect && !stop;
         pc_reg <= redirect ? (redirect_pc & ~INST_SIZE'(3)) : pc_reg + INST_SIZE'(4);
         pc <= pc_d1;
         inst <= take ? imem_rdata : INST_NOP;
         valid <= take;
         fetch_count <= fetch_count + 32'(take);
         if (stop && !redirect) begin
            state <= HALT;
            halted <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed checks of fetch with a behavioural 1-cycle BRAM
module tb_fetch;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic stall = 1'b0;
   logic redirect = 1'b0;
   logic [9:0] redirect_pc = '0;
   logic [7:0] imem_addr;
   logic imem_en;
   logic [31:0] imem_rdata = '0;
   logic [9:0] pc;
   logic [31:0] inst;
   logic valid, halted;
   logic [31:0] fetch_count;
   logic [31:0] mem [256];
   int n_checks = 0;
   int n_fail = 0;

   fetch #(.INST_SIZE(10), .RESET_PC(10'h0)) dut (
      .clk(clk), .rst(rst), .start(start), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_en(imem_en),
      .imem_rdata(imem_rdata), .pc(pc), .inst(inst), .valid(valid),
      .halted(halted), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic load_mem;
      for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
   endtask

   task automatic do_reset;
      rst = 1'b1; start = 1'b0; stall = 1'b0; redirect = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic do_start;
      start = 1'b1; tick(); start = 1'b0;
      tick();
   endtask

   task automatic test_reset;
      load_mem();
      do_reset();
      n_checks++;
      if ({pc, inst, valid, halted, fetch_count, imem_en} !== 76'h0) begin
         n_fail++;
         $display("FAIL reset: pc=%h inst=%h valid=%b halted=%b cnt=%0d en=%b, want all zero", pc, inst, valid, halted, fetch_count, imem_en);
      end
      tick();
      n_checks++;
      if ({valid, imem_en} !== 2'b00) begin
         n_fail++;
         $display("FAIL idle: valid=%b en=%b, want 0 0", valid, imem_en);
      end
   endtask

   task automatic test_basic;
      logic [31:0] prog [4];
      prog[0] = 32'h2001_0001; prog[1] = 32'h2002_0002; prog[2] = 32'h0022_1820; prog[3] = 32'h0000_003E;
      load_mem();
      for (int i = 0; i < 4; i++) mem[i] = prog[i];
      do_reset();
      do_start();
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if ({pc, inst, valid} !== {10'(4 * i), prog[i], 1'b1}) begin
            n_fail++;
            $display("FAIL basic%0d: pc=%h inst=%h valid=%b, want %h %h 1", i, pc, inst, valid, 10'(4 * i), prog[i]);
         end
      end
      n_checks++;
      if (halted !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_halt: halted=%b, want 1", halted);
      end
      tick();
      n_checks++;
      if ({valid, inst, halted, fetch_count, imem_en} !== {1'b0, 32'h0, 1'b1, 32'd4, 1'b0}) begin
         n_fail++;
         $display("FAIL basic_after: valid=%b inst=%h halted=%b cnt=%0d en=%b, want 0 0 1 4 0", valid, inst, halted, fetch_count, imem_en);
      end
      start = 1'b1; redirect = 1'b1; redirect_pc = 10'h20;
      tick();
      start = 1'b0; redirect = 1'b0;
      tick(); tick();
      n_checks++;
      if ({valid, halted, fetch_count, imem_en} !== {1'b0, 1'b1, 32'd4, 1'b0}) begin
         n_fail++;
         $display("FAIL halt_sticky: valid=%b halted=%b cnt=%0d en=%b, want 0 1 4 0", valid, halted, fetch_count, imem_en);
      end
   endtask

   task automatic test_stall;
      load_mem();
      do_reset();
      do_start();
      tick(); tick();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if ({pc, inst, valid, fetch_count, imem_en} !== {10'h4, 32'h1000_0001, 1'b1, 32'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL stall%0d: pc=%h inst=%h valid=%b cnt=%0d en=%b, want 004 10000001 1 2 0", i, pc, inst, valid, fetch_count, imem_en);
         end
      end
      stall = 1'b0;
      tick();
      n_checks++;
      if ({pc, inst, valid, fetch_count} !== {10'h8, 32'h1000_0002, 1'b1, 32'd3}) begin
         n_fail++;
         $display("FAIL unstall: pc=%h inst=%h valid=%b cnt=%0d, want 008 10000002 1 3", pc, inst, valid, fetch_count);
      end
      tick();
      n_checks++;
      if ({pc, inst} !== {10'hC, 32'h1000_0003}) begin
         n_fail++;
         $display("FAIL unstall2: pc=%h inst=%h, want 00c 10000003", pc, inst);
      end
   endtask

   task automatic test_redirect;
      load_mem();
      do_reset();
      do_start();
      tick(); tick();
      redirect = 1'b1; redirect_pc = 10'h42;
      tick();
      redirect = 1'b0;
      n_checks++;
      if ({pc, valid} !== {10'h8, 1'b1}) begin
         n_fail++;
         $display("FAIL redir_edge: pc=%h valid=%b, want 008 1", pc, valid);
      end
      tick();
      n_checks++;
      if ({valid, inst} !== 33'h0) begin
         n_fail++;
         $display("FAIL redir_bubble: valid=%b inst=%h, want 0 0", valid, inst);
      end
      tick();
      n_checks++;
      if ({pc, inst, valid} !== {10'h40, 32'h1000_0010, 1'b1}) begin
         n_fail++;
         $display("FAIL redir_t0: pc=%h inst=%h valid=%b, want 040 10000010 1", pc, inst, valid);
      end
      tick();
      n_checks++;
      if ({pc, inst, valid, fetch_count} !== {10'h44, 32'h1000_0011, 1'b1, 32'd5}) begin
         n_fail++;
         $display("FAIL redir_t1: pc=%h inst=%h valid=%b cnt=%0d, want 044 10000011 1 5", pc, inst, valid, fetch_count);
      end
      stall = 1'b1; redirect = 1'b1; redirect_pc = 10'h10;
      tick();
      stall = 1'b0; redirect = 1'b0;
      n_checks++;
      if ({pc, inst, valid} !== {10'h48, 32'h1000_0012, 1'b1}) begin
         n_fail++;
         $display("FAIL stall_redir_edge: pc=%h inst=%h valid=%b, want 048 10000012 1", pc, inst, valid);
      end
      tick();
      n_checks++;
      if ({valid, inst} !== 33'h0) begin
         n_fail++;
         $display("FAIL stall_redir_bubble: valid=%b inst=%h, want 0 0", valid, inst);
      end
      tick();
      n_checks++;
      if ({pc, inst, valid} !== {10'h10, 32'h1000_0004, 1'b1}) begin
         n_fail++;
         $display("FAIL stall_redir_t0: pc=%h inst=%h valid=%b, want 010 10000004 1", pc, inst, valid);
      end
   endtask

   task automatic test_wrap_stop;
      load_mem();
      mem[255] = 32'h0000_003E;
      do_reset();
      do_start();
      tick();
      redirect = 1'b1; redirect_pc = 10'h3FC;
      tick();
      redirect = 1'b0;
      tick();
      tick();
      n_checks++;
      if ({pc, inst, valid, halted} !== {10'h3FC, 32'h0000_003E, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL wrap_stop: pc=%h inst=%h valid=%b halted=%b, want 3fc 0000003e 1 1", pc, inst, valid, halted);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if ({valid, halted, fetch_count} !== {1'b0, 1'b1, 32'd3}) begin
            n_fail++;
            $display("FAIL wrap_after%0d: valid=%b halted=%b cnt=%0d, want 0 1 3", i, valid, halted, fetch_count);
         end
      end
   endtask

   task automatic test_stop_redirect;
      load_mem();
      mem[2] = 32'h0000_003E;
      do_reset();
      do_start();
      tick(); tick();
      redirect = 1'b1; redirect_pc = 10'h20;
      tick();
      redirect = 1'b0;
      n_checks++;
      if ({valid, inst, halted, fetch_count} !== {1'b0, 32'h0, 1'b0, 32'd2}) begin
         n_fail++;
         $display("FAIL stop_squash: valid=%b inst=%h halted=%b cnt=%0d, want 0 0 0 2", valid, inst, halted, fetch_count);
      end
      tick(); tick();
      n_checks++;
      if ({pc, inst, valid, halted, fetch_count} !== {10'h20, 32'h1000_0008, 1'b1, 1'b0, 32'd3}) begin
         n_fail++;
         $display("FAIL stop_redir_target: pc=%h inst=%h valid=%b halted=%b cnt=%0d, want 020 10000008 1 0 3", pc, inst, valid, halted, fetch_count);
      end
   endtask

   task automatic test_rst_mid;
      load_mem();
      do_reset();
      do_start();
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if ({pc, inst, valid, halted, fetch_count, imem_en} !== 76'h0) begin
         n_fail++;
         $display("FAIL rst_mid: pc=%h inst=%h valid=%b halted=%b cnt=%0d en=%b, want all zero", pc, inst, valid, halted, fetch_count, imem_en);
      end
      tick();
      n_checks++;
      if ({valid, imem_en} !== 2'b00) begin
         n_fail++;
         $display("FAIL rst_idle: valid=%b en=%b, want 0 0", valid, imem_en);
      end
      do_start();
      tick();
      n_checks++;
      if ({pc, inst, valid, fetch_count} !== {10'h0, 32'h1000_0000, 1'b1, 32'd1}) begin
         n_fail++;
         $display("FAIL restart: pc=%h inst=%h valid=%b cnt=%0d, want 000 10000000 1 1", pc, inst, valid, fetch_count);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_redirect();
      test_wrap_stop();
      test_stop_redirect();
      test_rst_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
